// File: rtl/div_unit_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_unit_pkg
//   Shared definitions for the iterative HI/LO divider.
//   - state_t       : divider FSM encoding
//   - WIDTH_DEFAULT : default operand width
//   - WIDTH_MAX     : widest operand width supported by DZERO_QUOT
//   - DZERO_QUOT    : quotient written on divide-by-zero (all ones); slice
//                     the low WIDTH bits
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int WIDTH_MAX     = 64;

    localparam logic [WIDTH_MAX-1:0] DZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        DZERO = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/div_unit_step.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring division step.
//   Ports:
//     rem      in   WIDTH  partial remainder (always < divisor)
//     q_msb    in   1      next dividend bit shifted into the remainder
//     divisor  in   WIDTH  divisor magnitude
//     rem_next out  WIDTH  updated partial remainder
//     q_bit    out  1      quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The shifted remainder is kept one bit wider than the operands: with a
    // divisor above 2^(WIDTH-1) the value 2*rem+bit can exceed WIDTH bits, and
    // dropping that carry would give wrong quotients.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   selected;
    logic             unused_carry;

    assign shifted  = {rem, q_msb};
    assign diff     = {1'b0, shifted} - {2'b00, divisor};
    // Top bit of the difference is the borrow: set means "restore".
    assign q_bit    = ~diff[WIDTH+1];
    assign selected = q_bit ? diff[WIDTH:0] : shifted;
    // After a successful subtract or a restore the result is below the
    // divisor, so its top bit is always zero.
    assign rem_next     = selected[WIDTH-1:0];
    assign unused_carry = selected[WIDTH];

endmodule

// File: rtl/div_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider producing HI/LO for DIV/DIVU.
//   Remainder goes to HI, quotient to LO. One quotient bit per cycle; holds
//   the pipeline while a division is in flight; a cancel drops the operation
//   so a flushed DIV never writes HI/LO.
//   Ports:
//     clk          in   1        clock, all state on posedge
//     reset        in   1        synchronous, active-high
//     start        in   1        DIV/DIVU in EX, sampled only in IDLE
//     is_signed    in   1        1 = DIV (two's complement), 0 = DIVU
//     dividend     in   WIDTH    rs operand, latched at start
//     divisor      in   WIDTH    rt operand, latched at start
//     cancel       in   1        flush/exception, aborts the operation
//     stall_req    out  1        combinational pipeline hold
//     busy         out  1        registered, high while state != IDLE
//     hilo_output  out  2*WIDTH  {remainder, quotient}, registered
//     hilo_wen     out  1        one-cycle HI/LO write pulse in DONE
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               cancel,
    output logic               stall_req,
    output logic               busy,
    output logic [2*WIDTH-1:0] hilo_output,
    output logic               hilo_wen
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    // Two's-complement negate when neg is set. Used both to take magnitudes
    // and to fix up result signs; the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] cond_negate(
        input logic [WIDTH-1:0] value,
        input logic             neg
    );
        logic signed [WIDTH-1:0] sval;
        sval = signed'(value);
        return neg ? unsigned'(-sval) : value;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] counter;

    // Iteration datapath: quo starts as the dividend magnitude and is shifted
    // left each step, the new quotient bit entering at the LSB.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] quo_next;

    logic             accept;
    logic             last_iter;

    assign accept    = (state == IDLE) && start && !cancel;
    assign last_iter = (state == DIV) && !cancel && (counter == LAST);
    assign quo_next  = {quo[WIDTH-2:0], q_bit};

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .q_msb    (quo[WIDTH-1]),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Next state and combinational outputs.
    always_comb begin
        state_next = state;
        stall_req  = 1'b0;
        hilo_wen   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cancel) begin
                    stall_req  = 1'b1;
                    state_next = (divisor == '0) ? DZERO : DIV;
                end
            end
            DIV: begin
                stall_req = 1'b1;
                if (cancel) begin
                    state_next = IDLE;
                end else if (counter == LAST) begin
                    state_next = DONE;
                end
            end
            DZERO: begin
                stall_req  = 1'b1;
                state_next = cancel ? IDLE : DONE;
            end
            DONE: begin
                // stall_req stays low so the DIV leaves EX as HI/LO is written.
                hilo_wen   = !cancel;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state and the result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            busy        <= 1'b0;
            hilo_output <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);

            if (state == DIV) begin
                counter <= counter + CNT_W'(1);
            end else begin
                counter <= '0;
            end

            // The result is captured on the edge into DONE so it is stable
            // for the whole write cycle and held afterwards.
            if (last_iter) begin
                hilo_output <= {cond_negate(rem_next, neg_rem),
                                cond_negate(quo_next, neg_quo)};
            end else if ((state == DZERO) && !cancel) begin
                hilo_output <= {quo, DZERO_QUOT[WIDTH-1:0]};
            end
        end
    end

    // Operand latch and iteration registers; no reset needed, every field is
    // written at start before it is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem     <= '0;
            dvsr    <= cond_negate(divisor, is_signed & divisor[WIDTH-1]);
            // On divide-by-zero the raw dividend is kept for HI.
            quo     <= (divisor == '0) ? dividend
                                       : cond_negate(dividend, is_signed & dividend[WIDTH-1]);
            neg_quo <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem <= is_signed & dividend[WIDTH-1];
        end else if (state == DIV) begin
            rem <= rem_next;
            quo <= quo_next;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit (WIDTH = 32). Inputs change 1ns after the
//   rising edge, outputs are sampled on the falling edge. Cycle cN is the Nth
//   clock period counted from the one in which start is driven high.
// -----------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           cancel;
    logic           stall_req;
    logic           busy;
    logic [2*W-1:0] hilo_output;
    logic           hilo_wen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .stall_req   (stall_req),
        .busy        (busy),
        .hilo_output (hilo_output),
        .hilo_wen    (hilo_wen)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division. SystemVerilog / and % truncate toward
    // zero, which gives the remainder the dividend's sign; the 64-bit
    // intermediate makes 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation starting in the next cycle (c0) and checks latency,
    // result, stall behaviour and return to idle. junk: 0 = quiet inputs while
    // busy, 1 = random start/operands every cycle, 2 = start pulse plus new
    // operands at c3 and c20 only.
    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int junk, input string tag, output logic [63:0] got);
        logic [63:0] exp;
        int          lat;
        int          wen_cyc;
        logic        gap;
        exp = model(sgn, a, b);
        lat = (b == 32'd0) ? 2 : W + 1;
        tick();
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        cancel    = 1'b0;
        @(negedge clk);
        check({tag, " stall_c0"}, 64'(stall_req), 64'd1);
        wen_cyc = -1;
        gap     = 1'b0;
        got     = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
            if (junk == 1) begin
                start     = 1'($urandom_range(0, 1));
                dividend  = $urandom;
                divisor   = $urandom;
                is_signed = 1'($urandom_range(0, 1));
            end else if (junk == 2 && (c == 3 || c == 20)) begin
                start     = 1'b1;
                dividend  = $urandom;
                divisor   = $urandom;
                is_signed = ~sgn;
            end
            @(negedge clk);
            if (hilo_wen) begin
                wen_cyc = c;
                got     = hilo_output;
                check({tag, " stall_done"}, 64'(stall_req), 64'd0);
                check({tag, " busy_done"}, 64'(busy), 64'd1);
                break;
            end
            if (!stall_req) gap = 1'b1;
        end
        check({tag, " wen_cycle"}, 64'(wen_cyc), 64'(lat));
        check({tag, " result"}, got, exp);
        check({tag, " stall_gap"}, 64'(gap), 64'd0);
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        check({tag, " wen_pulse_end"}, 64'(hilo_wen), 64'd0);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        logic        wen_seen;
        logic        sgn;
        logic [31:0] a, b;
        int          cls;

        reset     = 1'b1;
        start     = 1'b0;
        cancel    = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset hilo_output", hilo_output, 64'd0);
        check("reset hilo_wen", 64'(hilo_wen), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset stall_req", 64'(stall_req), 64'd0);
        tick();
        reset = 1'b0;

        // Directed cases with hand-computed results.
        do_op(1'b0, 32'd100, 32'd7, 0, "divu_100_7", got);
        check("divu_100_7 const", got, {32'd2, 32'd14});
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2", got);
        check("div_m7_2 const", got, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2", got);
        check("div_7_m2 const", got, {32'd1, 32'hFFFF_FFFD});
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1", got);
        check("div_min_m1 const", got, {32'd0, 32'h8000_0000});
        do_op(1'b0, 32'd5, 32'd0, 0, "divu_5_0", got);
        check("divu_5_0 const", got, {32'd5, 32'hFFFF_FFFF});
        do_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, "divu_big_divisor", got);

        // Cancel at c10 of a DIV: idle at c11, no write, then a fresh start.
        tick();
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        wen_seen  = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            start  = 1'b0;
            cancel = (c == 10);
            @(negedge clk);
            if (hilo_wen) wen_seen = 1'b1;
            if (c == 10) check("cancel stall_c10", 64'(stall_req), 64'd1);
            if (c == 11) begin
                check("cancel busy_c11", 64'(busy), 64'd0);
                check("cancel stall_c11", 64'(stall_req), 64'd0);
            end
        end
        check("cancel no_wen", 64'(wen_seen), 64'd0);
        do_op(1'b1, 32'hFFFF_FC18, 32'd3, 0, "after_cancel", got);

        // Cancel while in DONE suppresses the write.
        tick();
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd0;
        tick();
        start = 1'b0;
        tick();
        cancel = 1'b1;
        @(negedge clk);
        check("cancel_done wen_c2", 64'(hilo_wen), 64'd0);
        tick();
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_done busy_c3", 64'(busy), 64'd0);

        // Reset at c5 of a running DIV clears everything at c6.
        do_op(1'b0, 32'd77, 32'd5, 0, "pre_reset", got);
        tick();
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd123456;
        divisor   = 32'd789;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
            reset = (c == 5);
            @(negedge clk);
        end
        check("midreset hilo_output", hilo_output, 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset wen", 64'(hilo_wen), 64'd0);
        check("midreset stall", 64'(stall_req), 64'd0);
        tick();
        reset = 1'b0;

        // Start pulses and operand changes at c3 and c20 must be ignored.
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 2, "ignore_restart", got);
        check("ignore_restart const", got, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

        // Randomised operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            cls = int'($urandom_range(0, 5));
            case (cls)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                default: ;
            endcase
            do_op(sgn, a, b, (i % 3 == 0) ? 1 : 0, $sformatf("rand%0d", i), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
